// File: rtl/ram_port_ctrl.sv
// ram_port_ctrl: valid/ready initiator for a one-hot word-select bit-sliced RAM port.
// Define RAM_PORT_CTRL_VERIFY_EN for post-write readback with sticky verify_err.
module ram_port_ctrl #(
  parameter int ADDR_W  = 2,
  parameter int DATA_W  = 4,
  parameter int WR_HOLD = 2,
  parameter int RD_WAIT = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_we,
  input  logic [ADDR_W-1:0]        req_addr,
  input  logic [DATA_W-1:0]        req_wdata,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [DATA_W-1:0]        rsp_rdata,
  input  logic                     clear_start,
  output logic                     busy,
  output logic                     mem_rw,
  output logic [(1<<ADDR_W)-1:0]   mem_wordselect,
  output logic [DATA_W-1:0]        mem_data,
  input  logic [DATA_W-1:0]        mem_out
`ifdef RAM_PORT_CTRL_VERIFY_EN
  ,
  output logic                     verify_err
`endif
);

  localparam int WORDS = 1 << ADDR_W;
  localparam int CMAX  = (WR_HOLD > RD_WAIT) ? WR_HOLD : RD_WAIT;
  localparam int CNT_W = $clog2(CMAX + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_READ,
    S_RESP,
    S_CLEAR
`ifdef RAM_PORT_CTRL_VERIFY_EN
    ,
    S_VERIFY
`endif
  } state_t;

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [ADDR_W-1:0] widx;
`ifdef RAM_PORT_CTRL_VERIFY_EN
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] vdata;
`endif

  function automatic logic [WORDS-1:0] onehot(
    input logic [ADDR_W-1:0] a
  );
    return WORDS'(1) << a;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= S_IDLE;
      cnt            <= '0;
      widx           <= '0;
      req_ready      <= 1'b0;
      rsp_valid      <= 1'b0;
      rsp_rdata      <= '0;
      busy           <= 1'b0;
      mem_rw         <= 1'b0;
      mem_wordselect <= '0;
      mem_data       <= '0;
`ifdef RAM_PORT_CTRL_VERIFY_EN
      wdata_q        <= '0;
      vdata          <= '0;
      verify_err     <= 1'b0;
`endif
    end else begin
      unique case (state)
        S_IDLE: begin
          // clear wins over a same-cycle request
          if (clear_start) begin
            state          <= S_CLEAR;
            req_ready      <= 1'b0;
            busy           <= 1'b1;
            cnt            <= '0;
            widx           <= '0;
            mem_rw         <= 1'b1;
            mem_data       <= '0;
            mem_wordselect <= onehot('0);
          end else if (req_valid && req_ready) begin
            req_ready      <= 1'b0;
            busy           <= 1'b1;
            cnt            <= '0;
            mem_wordselect <= onehot(req_addr);
`ifdef RAM_PORT_CTRL_VERIFY_EN
            wdata_q        <= req_wdata;
`endif
            if (req_we) begin
              state    <= S_WRITE;
              mem_rw   <= 1'b1;
              mem_data <= req_wdata;
            end else begin
              state    <= S_READ;
              mem_rw   <= 1'b0;
              mem_data <= '0;
            end
          end else begin
            req_ready <= 1'b1;
          end
        end

        S_WRITE: begin
          if (cnt == CNT_W'(WR_HOLD - 1)) begin
            cnt      <= '0;
            mem_rw   <= 1'b0;
            mem_data <= '0;
`ifdef RAM_PORT_CTRL_VERIFY_EN
            state    <= S_VERIFY;
`else
            state          <= S_IDLE;
            mem_wordselect <= '0;
            req_ready      <= 1'b1;
            busy           <= 1'b0;
`endif
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        S_READ: begin
          if (cnt == CNT_W'(RD_WAIT - 1)) begin
            cnt            <= '0;
            rsp_rdata      <= mem_out;
            rsp_valid      <= 1'b1;
            mem_wordselect <= '0;
            state          <= S_RESP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        S_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
            busy      <= 1'b0;
            state     <= S_IDLE;
          end
        end

        S_CLEAR: begin
          if (cnt == CNT_W'(WR_HOLD - 1)) begin
            cnt <= '0;
            if (widx == ADDR_W'(WORDS - 1)) begin
              state          <= S_IDLE;
              mem_rw         <= 1'b0;
              mem_wordselect <= '0;
              req_ready      <= 1'b1;
              busy           <= 1'b0;
            end else begin
              widx           <= widx + 1'b1;
              mem_wordselect <= onehot(widx + 1'b1);
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

`ifdef RAM_PORT_CTRL_VERIFY_EN
        // sample on the RD_WAIT-th cycle, compare one cycle later
        S_VERIFY: begin
          if (cnt == CNT_W'(RD_WAIT - 1)) begin
            vdata          <= mem_out;
            mem_wordselect <= '0;
            cnt            <= cnt + 1'b1;
          end else if (cnt == CNT_W'(RD_WAIT)) begin
            if (vdata != wdata_q) verify_err <= 1'b1;
            cnt       <= '0;
            state     <= S_IDLE;
            req_ready <= 1'b1;
            busy      <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
`endif

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_port_ctrl.sv
// tb_ram_port_ctrl: randomized self-checking bench for ram_port_ctrl.
// A bench RAM sits on the mem_* pins; an expected-contents array predicts reads.
`timescale 1ns/1ps
module tb_ram_port_ctrl;
  localparam int ADDR_W  = 2;
  localparam int DATA_W  = 4;
  localparam int WR_HOLD = 2;
  localparam int RD_WAIT = 1;
  localparam int WORDS   = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;
  logic              clear_start;
  logic              busy;
  logic              mem_rw;
  logic [WORDS-1:0]  mem_wordselect;
  logic [DATA_W-1:0] mem_data;
  logic [DATA_W-1:0] mem_out;
`ifdef RAM_PORT_CTRL_VERIFY_EN
  logic              verify_err;
`endif

  logic [DATA_W-1:0] ram [WORDS] = '{default: '0};
  logic [DATA_W-1:0] exp_mem [WORDS];
  logic              exp_verr;
  int                tests = 0;
  int                fails = 0;

  always #5 clk = ~clk;

  ram_port_ctrl #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .WR_HOLD(WR_HOLD),
    .RD_WAIT(RD_WAIT)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_we        (req_we),
    .req_addr      (req_addr),
    .req_wdata     (req_wdata),
    .rsp_valid     (rsp_valid),
    .rsp_ready     (rsp_ready),
    .rsp_rdata     (rsp_rdata),
    .clear_start   (clear_start),
    .busy          (busy),
    .mem_rw        (mem_rw),
    .mem_wordselect(mem_wordselect),
    .mem_data      (mem_data),
    .mem_out       (mem_out)
`ifdef RAM_PORT_CTRL_VERIFY_EN
    ,
    .verify_err    (verify_err)
`endif
  );

  // what the array cell actually keeps (bit0 stuck-at-0 in the verify build)
  function automatic logic [DATA_W-1:0] stored(input logic [DATA_W-1:0] d);
`ifdef RAM_PORT_CTRL_VERIFY_EN
    return d & 4'hE;
`else
    return d;
`endif
  endfunction

  function automatic logic [WORDS-1:0] onehot(input int a);
    return WORDS'(1) << a;
  endfunction

  always @(posedge clk)
    if (mem_rw)
      for (int i = 0; i < WORDS; i++)
        if (mem_wordselect[i]) ram[i] <= stored(mem_data);

  always_comb begin
    mem_out = '0;
    for (int i = 0; i < WORDS; i++)
      if (mem_wordselect[i]) mem_out = mem_out | ram[i];
  end

  task automatic wait_ready();
    int n = 0;
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      tests++;
      fails++;
      $display("FAIL wait_ready: req_ready=%b after %0d cycles, want 1", req_ready, n);
    end
  endtask

  task automatic check_idle_zero(input string tag, input logic rdy);
    tests++;
    if ({mem_wordselect, mem_rw, mem_data, rsp_valid, busy, req_ready}
        !== {4'b0, 1'b0, 4'h0, 1'b0, 1'b0, rdy}) begin
      fails++;
      $display("FAIL %s: sel=%b rw=%b data=%h rv=%b busy=%b rdy=%b want all 0, rdy=%b",
               tag, mem_wordselect, mem_rw, mem_data, rsp_valid, busy, req_ready, rdy);
    end
  endtask

  // called on the first negedge after a write handshake
  task automatic write_phase(input int a, input logic [DATA_W-1:0] d);
    for (int k = 1; k <= WR_HOLD; k++) begin
      if (k > 1) @(negedge clk);
      tests++;
      if ({mem_wordselect, mem_rw, mem_data, req_ready, busy, rsp_valid}
          !== {onehot(a), 1'b1, d, 1'b0, 1'b1, 1'b0}) begin
        fails++;
        $display("FAIL write_hold k=%0d: sel=%b rw=%b data=%h rdy=%b busy=%b want sel=%b rw=1 data=%h rdy=0 busy=1",
                 k, mem_wordselect, mem_rw, mem_data, req_ready, busy, onehot(a), d);
      end
    end
`ifdef RAM_PORT_CTRL_VERIFY_EN
    for (int k = 1; k <= RD_WAIT; k++) begin
      @(negedge clk);
      tests++;
      if ({mem_wordselect, mem_rw, req_ready, busy} !== {onehot(a), 1'b0, 1'b0, 1'b1}) begin
        fails++;
        $display("FAIL verify_sel k=%0d: sel=%b rw=%b rdy=%b busy=%b want sel=%b rw=0 rdy=0 busy=1",
                 k, mem_wordselect, mem_rw, req_ready, busy, onehot(a));
      end
    end
    @(negedge clk);
    tests++;
    if ({mem_wordselect, mem_rw, req_ready, busy} !== {4'b0, 1'b0, 1'b0, 1'b1}) begin
      fails++;
      $display("FAIL verify_gap: sel=%b rw=%b rdy=%b busy=%b want sel=0 rw=0 rdy=0 busy=1",
               mem_wordselect, mem_rw, req_ready, busy);
    end
`endif
    @(negedge clk);
    check_idle_zero("write_done", 1'b1);
    exp_mem[a] = stored(d);
`ifdef RAM_PORT_CTRL_VERIFY_EN
    exp_verr = exp_verr | (stored(d) != d);
    tests++;
    if (verify_err !== exp_verr) begin
      fails++;
      $display("FAIL verify_err: got %b want %b", verify_err, exp_verr);
    end
`endif
  endtask

  task automatic do_write(input int a, input logic [DATA_W-1:0] d);
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_addr  = ADDR_W'(a);
    req_wdata = d;
    wait_ready();
    @(negedge clk);
    req_valid = 1'b0;
    write_phase(a, d);
  endtask

  task automatic do_read(input int a, input int hold);
    logic [DATA_W-1:0] want;
    want      = exp_mem[a];
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_addr  = ADDR_W'(a);
    req_wdata = DATA_W'($urandom);
    rsp_ready = 1'b0;
    wait_ready();
    @(negedge clk);
    req_valid = 1'b0;
    for (int k = 1; k <= RD_WAIT; k++) begin
      if (k > 1) @(negedge clk);
      tests++;
      if ({mem_wordselect, mem_rw, mem_data, rsp_valid, busy}
          !== {onehot(a), 1'b0, 4'h0, 1'b0, 1'b1}) begin
        fails++;
        $display("FAIL read_sel k=%0d: sel=%b rw=%b data=%h rv=%b busy=%b want sel=%b rw=0 data=0 rv=0 busy=1",
                 k, mem_wordselect, mem_rw, mem_data, rsp_valid, busy, onehot(a));
      end
    end
    for (int k = 0; k <= hold; k++) begin
      @(negedge clk);
      tests++;
      if ({rsp_valid, rsp_rdata, mem_wordselect, req_ready, busy}
          !== {1'b1, want, 4'b0, 1'b0, 1'b1}) begin
        fails++;
        $display("FAIL read_rsp k=%0d addr=%0d: rv=%b rdata=%h sel=%b rdy=%b busy=%b want rv=1 rdata=%h sel=0 rdy=0 busy=1",
                 k, a, rsp_valid, rsp_rdata, mem_wordselect, req_ready, busy, want);
      end
      if (k == hold) rsp_ready = 1'b1;
    end
    @(negedge clk);
    rsp_ready = 1'b0;
    check_idle_zero("read_done", 1'b1);
  endtask

  // called on the first negedge after clear was taken
  task automatic clear_sweep();
    for (int w = 0; w < WORDS; w++)
      for (int h = 0; h < WR_HOLD; h++) begin
        if (w + h > 0) @(negedge clk);
        clear_start = 1'b0;
        tests++;
        if ({mem_wordselect, mem_rw, mem_data, req_ready, busy}
            !== {onehot(w), 1'b1, 4'h0, 1'b0, 1'b1}) begin
          fails++;
          $display("FAIL clear w=%0d h=%0d: sel=%b rw=%b data=%h rdy=%b busy=%b want sel=%b rw=1 data=0 rdy=0 busy=1",
                   w, h, mem_wordselect, mem_rw, mem_data, req_ready, busy, onehot(w));
        end
        if (w == 2 && h == 0) clear_start = 1'b1;
      end
    @(negedge clk);
    clear_start = 1'b0;
    check_idle_zero("clear_done", 1'b1);
    for (int i = 0; i < WORDS; i++) begin
      tests++;
      if (ram[i] !== 4'h0) begin
        fails++;
        $display("FAIL clear_word%0d: ram=%h want 0", i, ram[i]);
      end
      exp_mem[i] = '0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check_idle_zero("reset", 1'b0);
    tests++;
    if (rsp_rdata !== 4'h0) begin
      fails++;
      $display("FAIL reset_rdata: got %h want 0", rsp_rdata);
    end
    rst = 1'b0;
    exp_verr = 1'b0;
    @(negedge clk);
    check_idle_zero("reset_release", 1'b1);
  endtask

  task automatic test_write();
    do_write(2, 4'hA);
  endtask

  task automatic test_write_read();
    do_write(1, 4'h5);
    do_read(1, 0);
  endtask

  task automatic test_backpressure();
    do_write(3, 4'hC);
    do_read(3, 5);
  endtask

  task automatic test_clear_priority();
    logic [DATA_W-1:0] d;
    d = DATA_W'($urandom_range(1, 15));
    wait_ready();
    clear_start = 1'b1;
    req_valid   = 1'b1;
    req_we      = 1'b1;
    req_addr    = '0;
    req_wdata   = d;
    @(negedge clk);
    clear_sweep();
    @(negedge clk);
    req_valid = 1'b0;
    write_phase(0, d);
    for (int i = 0; i < WORDS; i++) do_read(i, 0);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(1) == 1)
        do_write(int'($urandom_range(3)), DATA_W'($urandom));
      else
        do_read(int'($urandom_range(3)), int'($urandom_range(3)));
    end
  endtask

  task automatic test_reset_mid_resp();
    int n = 0;
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_addr  = ADDR_W'($urandom);
    rsp_ready = 1'b0;
    wait_ready();
    @(negedge clk);
    req_valid = 1'b0;
    while (!rsp_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    tests++;
    if (rsp_valid !== 1'b1) begin
      fails++;
      $display("FAIL mid_resp_setup: rsp_valid=%b want 1", rsp_valid);
    end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_idle_zero("reset_in_resp", 1'b0);
    rst = 1'b0;
    exp_verr = 1'b0;
    @(negedge clk);
    check_idle_zero("after_resp_reset", 1'b1);
    do_read(int'($urandom_range(3)), 1);
  endtask

  task automatic test_reset_mid_clear();
    wait_ready();
    clear_start = 1'b1;
    @(negedge clk);
    clear_start = 1'b0;
    repeat (2) @(negedge clk);
    tests++;
    if (busy !== 1'b1) begin
      fails++;
      $display("FAIL mid_clear_setup: busy=%b want 1", busy);
    end
    rst = 1'b1;
    @(negedge clk);
    check_idle_zero("reset_in_clear", 1'b0);
    rst = 1'b0;
    exp_verr = 1'b0;
    @(negedge clk);
    check_idle_zero("after_clear_reset", 1'b1);
    clear_start = 1'b1;
    @(negedge clk);
    clear_sweep();
    for (int i = 0; i < WORDS; i++) do_read(i, 0);
  endtask

`ifdef RAM_PORT_CTRL_VERIFY_EN
  task automatic test_verify();
    test_reset();
    tests++;
    if (verify_err !== 1'b0) begin
      fails++;
      $display("FAIL verify_reset: got %b want 0", verify_err);
    end
    do_write(1, 4'h1);
    do_write(2, 4'h2);
    do_read(2, 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_verr = 1'b0;
    tests++;
    if (verify_err !== 1'b0) begin
      fails++;
      $display("FAIL verify_clear_by_rst: got %b want 0", verify_err);
    end
    @(negedge clk);
  endtask
`endif

  initial begin
    rst         = 1'b1;
    req_valid   = 1'b0;
    req_we      = 1'b0;
    req_addr    = '0;
    req_wdata   = '0;
    rsp_ready   = 1'b0;
    clear_start = 1'b0;
    exp_verr    = 1'b0;
    for (int i = 0; i < WORDS; i++) exp_mem[i] = '0;
    test_reset();
    test_write();
    test_write_read();
    test_backpressure();
    test_clear_priority();
    test_back_to_back();
    test_reset_mid_resp();
    test_reset_mid_clear();
`ifdef RAM_PORT_CTRL_VERIFY_EN
    test_verify();
`endif
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule

// File: doc/ram_port_ctrl.md
Name: ram_port_ctrl

Overview:
- Initiator side of the 4-word x 4-bit bit-sliced RAM port: one-hot word select, shared rw strobe, write data bus, read data return.
- Accepts single read/write requests on a valid/ready front end and sequences the RAM port signals with fixed hold and wait times.
- Returns read data on a valid/ready response channel.
- Also provides a whole-array clear sweep.
- Sits between the datapath/sequencer and the memory array.

Parameters:
- ADDR_W, 2, word address width; word count is 2**ADDR_W (4).
- DATA_W, 4, data width per word.
- WR_HOLD, 2, cycles mem_rw/mem_wordselect/mem_data are held for a write (>=1).
- RD_WAIT, 1, cycles between asserting read select and sampling mem_out (>=1).

Ports:
- clk  in  1  clock; all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- req_valid  in  1  request present
- req_ready  out  1  controller can accept a request
- req_we  in  1  1 = write, 0 = read
- req_addr  in  ADDR_W  word address
- req_wdata  in  DATA_W  write data
- rsp_valid  out  1  read data valid
- rsp_ready  in  1  consumer accepts read data
- rsp_rdata  out  DATA_W  read data
- clear_start  in  1  one-cycle pulse: zero all words
- busy  out  1  high whenever state != IDLE
- mem_rw  out  1  RAM rw strobe; 1 = write, 0 = read
- mem_wordselect  out  2**ADDR_W  one-hot word select; all-zero when idle
- mem_data  out  DATA_W  RAM write data
- mem_out  in  DATA_W  RAM read data

Behaviour:
- Reset (rst high at clock edge):
  - state=IDLE; req_ready=0 during reset, 1 the cycle after.
  - rsp_valid=0, rsp_rdata=0, busy=0.
  - mem_rw=0, mem_wordselect=0, mem_data=0.
  - Counters cleared.
  - Reset mid-operation abandons the operation immediately; a pending response is dropped.
- All outputs are registered. mem_wordselect has at most one bit set at all times.
- States: IDLE, WRITE, READ, RESP, CLEAR.
- IDLE:
  - req_ready=1.
  - Handshake req_valid&req_ready captures req_we, req_addr and req_wdata.
  - clear_start has priority over req_valid in the same cycle; the request is not accepted (req_ready stays 1 that cycle but is gated, so no handshake occurs).
  - clear_start -> CLEAR.
  - Accepted write -> WRITE; accepted read -> READ.
- WRITE:
  - mem_wordselect = 1<<addr, mem_rw=1, mem_data=wdata, held exactly WR_HOLD cycles.
  - Then all three return to 0 in the same cycle; next state IDLE.
  - Write-to-ready latency: WR_HOLD+1 cycles after the handshake.
- READ:
  - mem_wordselect = 1<<addr, mem_rw=0, mem_data=0.
  - mem_out is sampled into rsp_rdata on the RD_WAIT-th cycle of select.
  - Select drops the following cycle; -> RESP.
- RESP:
  - rsp_valid=1; rsp_rdata stable until rsp_valid&rsp_ready.
  - After that handshake: rsp_valid=0 next cycle; -> IDLE.
  - req_ready=0 while in RESP; there is no request overlap.
- CLEAR:
  - Sweeps words 0..2**ADDR_W-1 in ascending order.
  - Each word: mem_rw=1, mem_data=0, one-hot select, held WR_HOLD cycles.
  - No idle gap between words; the select bit moves directly.
  - After the last word, outputs go to 0; -> IDLE.
  - Total busy = 4*WR_HOLD cycles at defaults.
  - clear_start while busy is ignored.
- req_valid while busy: not accepted. The requester must hold req_valid/data until the handshake.
- Address wrap: not applicable; all 2**ADDR_W addresses are legal.

Optional Feature:
- Macro: RAM_PORT_CTRL_VERIFY_EN.
- When defined:
  - Each WRITE (not CLEAR) is followed by an automatic readback through a VERIFY state: same select, mem_rw=0, sample after RD_WAIT cycles.
  - Sampled value is compared to wdata; a mismatch sets sticky output verify_err (1 bit, cleared only by rst).
  - Write latency becomes WR_HOLD+RD_WAIT+2.
  - No response is generated.
- When undefined:
  - No VERIFY state and no verify_err port.
  - Write timing exactly as above.

Test Plan:
- Reset then write addr=2 data=4'hA -> mem_wordselect=4'b0100, mem_rw=1, mem_data=4'hA for exactly 2 cycles, then 0; req_ready returns 1 three cycles after the handshake.
- Write addr=1 data=4'h5, then read addr=1 with a bench RAM model -> mem_rw=0 with select 4'b0010 for 1 cycle; rsp_valid=1 with rsp_rdata=4'h5.
- Read with rsp_ready held 0 for 5 cycles -> rsp_valid and rsp_rdata stay stable, req_ready=0; data is accepted on the first rsp_ready=1 cycle.
- clear_start and req_valid(write addr=0) in the same cycle -> clear runs with selects 0001,0010,0100,1000, each for 2 cycles with mem_data=0; the write is accepted only after busy falls; readback of all words = 4'h0 before the write lands.
- Assert rst in the middle of a CLEAR and in the middle of a RESP -> the next cycle all mem_* outputs are 0, rsp_valid=0, busy=0, and the state is IDLE.
- With RAM_PORT_CTRL_VERIFY_EN, the bench model forces bit0 stuck-at-0; write 4'h1 -> verify_err=1 and stays set until rst; write 4'h2 -> no change to verify_err.
